conv_tile_ctrl: RTL and testbench

CONV_TILE_CTRL -- requirements
Module: conv_tile_ctrl

---
 rtl/conv_tile_ctrl_if.sv | 23 ++
 rtl/conv_tile_ctrl.sv | 148 ++++++++++++++
 tb/tb_conv_tile_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tile_ctrl_if.sv
// Load/result stream bundle for conv_tile_ctrl: word-serial operand input and handshaked result output.
// The master side belongs to the producer/consumer, and the slave side belongs to the controller.
interface conv_tile_ctrl_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_tile_ctrl.sv
// Tile controller for a 3x3-filter / 5x5-ifmap array: load operands, arm, run, capture and stream 9 results.
// Optional ReLU clamp on captured results when CONV_TILE_CTRL_RELU_EN is defined.
module conv_tile_ctrl #(
  parameter int DW         = 16,
  parameter int RUN_CYCLES = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  conv_tile_ctrl_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             arr_load,
  output logic             arr_en,
  output logic [9*DW-1:0]  arr_filter_flat,
  output logic [25*DW-1:0] arr_ifmap_flat,
  input  logic [9*DW-1:0]  arr_sum_flat
);

  typedef enum logic [2:0] {
    IDLE, LOAD_FILT, LOAD_IFMAP, ARM, RUN, CAPTURE, OUT
  } state_t;

  localparam logic [7:0] RUN_LAST = 8'(RUN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [4:0]            cnt_q;
  logic [7:0]            run_q;
  logic [3:0]            idx_q;
  logic [8:0][DW-1:0]    filt_q;
  logic [24:0][DW-1:0]   ifmap_q;
  logic [8:0][DW-1:0]    obuf_q;
  logic [8:0][DW-1:0]    cap;
  logic                  kill;
  logic                  in_rdy;
  logic                  out_vld;
  logic                  out_hs;
  logic                  done_q;

  assign kill = abort && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort overrides every transition and masks both stream handshakes in the same cycle
  always_comb begin
    state_d  = state_q;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    arr_load = 1'b0;
    arr_en   = 1'b0;
    case (state_q)
      IDLE:       if (start) state_d = LOAD_FILT;
      LOAD_FILT: begin
        in_rdy = 1'b1;
        if (bus.in_valid && cnt_q == 5'd8) state_d = LOAD_IFMAP;
      end
      LOAD_IFMAP: begin
        in_rdy = 1'b1;
        if (bus.in_valid && cnt_q == 5'd24) state_d = ARM;
      end
      ARM: begin
        arr_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        arr_en = 1'b1;
        if (run_q == RUN_LAST) state_d = CAPTURE;
      end
      CAPTURE:    state_d = OUT;
      OUT: begin
        out_vld = 1'b1;
        if (bus.out_ready && idx_q == 4'd8) state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
    end
  end

  always_comb begin
    cap = '0;
    for (int k = 0; k < 9; k++) begin
      cap[k] = arr_sum_flat[k*DW +: DW];
`ifdef CONV_TILE_CTRL_RELU_EN
      if (cap[k][DW-1]) cap[k] = '0;
`endif
    end
  end

  assign out_hs = out_vld && bus.out_ready;

  // operands are only written on accepted words, so an aborted load keeps the untouched words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      run_q   <= '0;
      idx_q   <= '0;
      filt_q  <= '0;
      ifmap_q <= '0;
      obuf_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= out_hs && (idx_q == 4'd8);
      if (kill) begin
        cnt_q <= '0;
        run_q <= '0;
        idx_q <= '0;
      end else begin
        case (state_q)
          LOAD_FILT: if (bus.in_valid) begin
            filt_q[cnt_q[3:0]] <= bus.in_data;
            cnt_q <= (cnt_q == 5'd8) ? 5'd0 : cnt_q + 5'd1;
          end
          LOAD_IFMAP: if (bus.in_valid) begin
            ifmap_q[cnt_q] <= bus.in_data;
            cnt_q <= (cnt_q == 5'd24) ? 5'd0 : cnt_q + 5'd1;
          end
          RUN:     run_q  <= (run_q == RUN_LAST) ? 8'd0 : run_q + 8'd1;
          CAPTURE: obuf_q <= cap;
          OUT: if (bus.out_ready) begin
            idx_q <= (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = out_vld;
  assign bus.out_data     = obuf_q[idx_q];
  assign bus.out_last     = out_vld && (idx_q == 4'd8);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign arr_filter_flat  = filt_q;
  assign arr_ifmap_flat   = ifmap_q;

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Bench for conv_tile_ctrl: table of tile scenarios with a result scoreboard, plus abort/reset sequences.
module tb_conv_tile_ctrl;
  localparam int DW   = 16;
  localparam int RUNC = 9;
  localparam int LAT  = 1 + 34 + 1 + RUNC + 1 + 9 + 1;

  typedef struct {
    bit          toggle;
    int          stall_at;
    int          stall_len;
    logic [15:0] w2;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, arr_load, arr_en;
  logic [9*DW-1:0]  filt_flat;
  logic [25*DW-1:0] ifmap_flat;
  logic [9*DW-1:0]  sum_flat;
  logic [DW-1:0]    stub [9];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   load_cnt = 0;
  int   en_cnt = 0;
  int   done_cnt = 0;
  bit   in_hs = 1'b0;
  exp_t q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  conv_tile_ctrl_if #(.DW(DW)) bus ();

  conv_tile_ctrl #(.DW(DW), .RUN_CYCLES(RUNC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .bus             (bus.slave),
    .busy            (busy),
    .done            (done),
    .arr_load        (arr_load),
    .arr_en          (arr_en),
    .arr_filter_flat (filt_flat),
    .arr_ifmap_flat  (ifmap_flat),
    .arr_sum_flat    (sum_flat)
  );

  always_comb begin
    sum_flat = '0;
    for (int k = 0; k < 9; k++) sum_flat[k*DW +: DW] = stub[k];
  end

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef CONV_TILE_CTRL_RELU_EN
    return w[15] ? 16'h0000 : w;
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // compared at the falling edge, half a cycle before the DUT acts on the handshake
  task automatic sample();
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got 0x%0h with empty scoreboard (cycle %0d)", bus.out_data, cyc);
      end else begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_last", bus.out_last, q[0].last);
        if (bus.out_ready) begin
          void'(q.pop_front());
          hs_cnt++;
        end
      end
    end
    if (arr_load) load_cnt++;
    if (arr_en) en_cnt++;
    if (done) done_cnt++;
    in_hs = bus.in_valid && bus.in_ready;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_words(input bit toggle, input int base, input int nwords);
    int n = 0;
    int g = 0;
    while (n < nwords && g < 300) begin
      bus.in_valid = toggle ? (g % 2 == 0) : 1'b1;
      bus.in_data  = DW'(base + n);
      tick();
      if (in_hs) n++;
      g++;
    end
    bus.in_valid = 1'b0;
    chk("load_words_accepted", n, nwords);
  endtask

  task automatic run_tile(input vec_t v);
    int t0, l0, e0, h0, d0, g, stall_left;
    for (int k = 0; k < 9; k++) stub[k] = DW'(100 + k);
    stub[2] = v.w2;
    for (int k = 0; k < 9; k++) q.push_back('{d: exp_word(stub[k]), last: (k == 8)});
    t0 = cyc; l0 = load_cnt; e0 = en_cnt; h0 = hs_cnt; d0 = done_cnt;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(v.toggle, 1, 34);
    chk("filter_w0", filt_flat[0 +: DW], 1);
    chk("filter_w8", filt_flat[8*DW +: DW], 9);
    chk("ifmap_w24", ifmap_flat[24*DW +: DW], 34);
    stall_left = v.stall_len;
    g = 0;
    while (!done && g < 400) begin
      if (v.stall_at >= 0 && hs_cnt - h0 == v.stall_at && stall_left > 0 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      tick();
      g++;
    end
    bus.out_ready = 1'b1;
    chk("done_seen", done, 1);
    if (v.exp_lat > 0) chk("latency", cyc - t0 + 1, v.exp_lat);
    chk("handshakes", hs_cnt - h0, 9);
    chk("arr_load_pulses", load_cnt - l0, 1);
    chk("arr_en_cycles", en_cnt - e0, RUNC);
    chk("scoreboard_empty", q.size(), 0);
    tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int d0, e0, h0, g;
    vecs[0] = '{toggle: 1'b0, stall_at: -1, stall_len: 0, w2: 16'd102,  exp_lat: LAT};
    vecs[1] = '{toggle: 1'b1, stall_at: -1, stall_len: 0, w2: 16'd102,  exp_lat: 0};
    vecs[2] = '{toggle: 1'b0, stall_at: 3,  stall_len: 5, w2: 16'd102,  exp_lat: LAT + 5};
    vecs[3] = '{toggle: 1'b0, stall_at: -1, stall_len: 0, w2: 16'h8003, exp_lat: LAT};
    for (int k = 0; k < 9; k++) stub[k] = DW'(100 + k);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_arr_load", arr_load, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_filter", filt_flat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_tile(vecs[i]);

    // partial filter load then abort: only the first five words change
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(1'b0, 50, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("pabort_busy", busy, 0);
    chk("pabort_in_ready", bus.in_ready, 0);
    chk("pabort_filter_w4", filt_flat[4*DW +: DW], 54);
    chk("pabort_filter_w5", filt_flat[5*DW +: DW], 6);
    chk("pabort_ifmap_w0", ifmap_flat[0 +: DW], 10);

    // abort on the 4th RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(1'b0, 1, 34);
    e0 = en_cnt;
    d0 = done_cnt;
    repeat (4) tick();
    chk("abort_run_en_before", arr_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_busy", busy, 0);
    chk("abort_run_en_after", arr_en, 0);
    chk("abort_run_en_cycles", en_cnt - e0, 4);
    repeat (60) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_tile(vecs[0]);

    // reset asserted in OUT with idx=5
    for (int k = 0; k < 9; k++) stub[k] = DW'(100 + k);
    for (int k = 0; k < 9; k++) q.push_back('{d: exp_word(stub[k]), last: (k == 8)});
    h0 = hs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_words(1'b0, 1, 34);
    g = 0;
    while (hs_cnt - h0 < 5 && g < 200) begin
      tick();
      g++;
    end
    chk("rst_mid_reached_idx5", hs_cnt - h0, 5);
    chk("rst_mid_valid_before", bus.out_valid, 1);
    chk("rst_mid_data_before", bus.out_data, 105);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_out_last", bus.out_last, 0);
    chk("rst_mid_out_data", bus.out_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_filter", filt_flat, 0);
    q.delete();
    d0 = done_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_tile(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
